hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB). The pipeline has no forwarding.
- Detects RAW hazards at ID against the EX/MEM/WB destinations. It then holds PC and IF/ID for a counted number of cycles and injects ID/EX bubbles.
- Sequences redirects: jumps resolve in EX, taken branches resolve in MEM.
- Replaces the edge-triggered PC-decrement stall scheme with synchronous enables and PC-select outputs.

Parameters:
- RA_W, 5, register address width
- CNT_W, 16, width of saturating performance counters

Ports:
- CLK  in  1  pipeline clock, all state on posedge
- RST_N  in  1  asynchronous active-low reset
- id_rs  in  RA_W  ID source register 1 (instr[25:21])
- id_rt  in  RA_W  ID source register 2 (instr[20:16])
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_wreg, mem_wreg, wb_wreg  in  RA_W each  destination register per stage
- ex_regwrite, mem_regwrite, wb_regwrite  in  1 each  stage will write the register file
- ex_jump  in  1  jump instruction in EX (JToPC in EX)
- mem_br_taken  in  1  branch in MEM with zero set
- pc_we  out  1  PC register load enable
- pc_sel  out  2  00 = PC+4, 01 = jump target (EX), 10 = branch target (MEM)
- ifid_we  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads a NOP (all controls 0)
- exmem_flush  out  1  EX/MEM loads a NOP
- stall_cnt  out  CNT_W  cycles spent in RAW stall, saturating
- flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- States: INIT, RUN, STALL. A 2-bit remaining-stall counter rem is kept.
- Reset (RST_N low, asynchronous):
  - state = INIT, rem = 0, stall_cnt = 0, flush_cnt = 0.
  - Outputs while in reset: pc_we = 0, ifid_we = 0, ifid_flush = 1, idex_bubble = 1, exmem_flush = 1, pc_sel = 00.
- INIT: the first cycle after release keeps the same outputs as reset, then goes to RUN unconditionally. This lets the first fetch settle.
- Hazard match, per stage X in {EX, MEM, WB}:
  - Condition: X_regwrite && X_wreg != 0 && ((id_use_rs && id_rs == X_wreg) || (id_use_rt && id_rt == X_wreg)).
  - Distance: d = 3 for EX, 2 for MEM, 1 for WB. The nearest stage wins, i.e. the largest d.
  - The register file does not bypass a WB write to the same-cycle read, so a WB match stalls 1 cycle.
- Priority each cycle: mem_br_taken > ex_jump > RAW hazard > normal.
- Branch taken (any state except INIT):
  - pc_we = 1, pc_sel = 10, ifid_flush = 1, idex_bubble = 1, exmem_flush = 1.
  - Next state RUN, rem cleared, flush_cnt += 1.
- Jump in EX, with no branch:
  - pc_we = 1, pc_sel = 01, ifid_flush = 1, idex_bubble = 1, exmem_flush = 0.
  - Next state RUN, rem cleared, flush_cnt += 1.
- RUN with a match at distance d:
  - Outputs: pc_we = 0, ifid_we = 0, idex_bubble = 1.
  - Next: if d > 1, go to STALL with rem = d-1; if d = 1, stay in RUN. That cycle alone is the stall.
  - stall_cnt += 1.
- STALL:
  - Outputs: pc_we = 0, ifid_we = 0, idex_bubble = 1, stall_cnt += 1.
  - rem decrements each cycle; when it reaches 1 it returns to RUN.
  - Total stall is exactly d cycles.
  - The counted stall is authoritative. Stage inputs are not re-checked, because bubbles carry regwrite = 0.
- A redirect during STALL aborts the stall: the stalled ID instruction is wrong-path. The redirect outputs apply in that cycle.
- Normal RUN: pc_we = 1, ifid_we = 1, pc_sel = 00, all flush/bubble outputs 0.
- Outputs are combinational from state, rem and inputs; no latency.
- Invariant: ifid_we = 0 whenever ifid_flush = 1. ifid_we is 0 during a redirect because the flush has load priority.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- Register $0 never causes a stall.

Decomposition:
- Shared pipeline package holds:
  - PC_SEL_SEQ = 2'b00, PC_SEL_JMP = 2'b01, PC_SEL_BR = 2'b10
  - State encoding INIT/RUN/STALL
  - RA_W
- One sub-module, hazard_match: combinational comparator returning a valid flag and the distance d for one ID instruction against three stages. It is instantiated once.
- The saturating counter is inline logic, not a module.

Test Plan:
- add $3 in EX, ID reads $3 (use_rs) -> pc_we = 0 and idex_bubble = 1 for exactly 3 cycles, then pc_we = 1; stall_cnt = 3.
- $3 writer in WB only -> 1 stall cycle, state stays RUN; a writer to $0 in EX -> 0 stall cycles.
- ex_jump = 1 in RUN -> same cycle pc_sel = 01, ifid_flush = 1, idex_bubble = 1, exmem_flush = 0; flush_cnt = 1.
- EX match starts a stall; on the second stall cycle mem_br_taken = 1 and ex_jump = 1 together -> pc_sel = 10, all three flushes asserted, next cycle RUN with pc_we = 1.
- RST_N pulsed low mid-STALL -> outputs immediately at reset values; after release one INIT cycle with pc_we = 0, then RUN; counters read 0.
- Force stall_cnt to 16'hFFFE, then run 3 stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_sched_pkg.sv
// Shared pipeline definitions for the stall/flush scheduler: PC-select codes,
// scheduler state encoding, register address width and the control bundle.
package hazard_sched_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_JMP = 2'b01;
  localparam logic [1:0] PC_SEL_BR  = 2'b10;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       exmem_flush;
  } ctrl_t;

  // INIT and reset share this bundle so the first fetch can settle.
  localparam ctrl_t CTRL_HOLD  = '{pc_we: 1'b0, pc_sel: PC_SEL_SEQ, ifid_we: 1'b0,
                                   ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_flush: 1'b1};
  localparam ctrl_t CTRL_SEQ   = '{pc_we: 1'b1, pc_sel: PC_SEL_SEQ, ifid_we: 1'b1,
                                   ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_flush: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_we: 1'b0, pc_sel: PC_SEL_SEQ, ifid_we: 1'b0,
                                   ifid_flush: 1'b0, idex_bubble: 1'b1, exmem_flush: 1'b0};
  localparam ctrl_t CTRL_BR    = '{pc_we: 1'b1, pc_sel: PC_SEL_BR, ifid_we: 1'b0,
                                   ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_flush: 1'b1};
  localparam ctrl_t CTRL_JMP   = '{pc_we: 1'b1, pc_sel: PC_SEL_JMP, ifid_we: 1'b0,
                                   ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_flush: 1'b0};

  // A writer to $0 never produces a dependency.
  function automatic logic src_hit(input logic            regwrite,
                                   input logic [RA_W-1:0] wreg,
                                   input logic [RA_W-1:0] rs,
                                   input logic [RA_W-1:0] rt,
                                   input logic            use_rs,
                                   input logic            use_rt);
    return regwrite && (wreg != '0) &&
           ((use_rs && (rs == wreg)) || (use_rt && (rt == wreg)));
  endfunction

endpackage

// File: rtl/hazard_match.sv
// RAW comparator for the ID instruction against the EX/MEM/WB destinations;
// reports whether a stall is needed and for how many cycles (nearest stage wins).
module hazard_match
  import hazard_sched_pkg::*;
(
  input  logic [RA_W-1:0] id_rs_i,
  input  logic [RA_W-1:0] id_rt_i,
  input  logic            id_use_rs_i,
  input  logic            id_use_rt_i,
  input  logic [RA_W-1:0] ex_wreg_i,
  input  logic [RA_W-1:0] mem_wreg_i,
  input  logic [RA_W-1:0] wb_wreg_i,
  input  logic            ex_regwrite_i,
  input  logic            mem_regwrite_i,
  input  logic            wb_regwrite_i,
  output logic            match_o,
  output logic [1:0]      dist_o
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = src_hit(ex_regwrite_i, ex_wreg_i, id_rs_i, id_rt_i,
                           id_use_rs_i, id_use_rt_i);
  assign mem_hit = src_hit(mem_regwrite_i, mem_wreg_i, id_rs_i, id_rt_i,
                           id_use_rs_i, id_use_rt_i);
  assign wb_hit  = src_hit(wb_regwrite_i, wb_wreg_i, id_rs_i, id_rt_i,
                           id_use_rs_i, id_use_rt_i);

  // WB still costs a cycle: the register file does not bypass same-cycle writes.
  always_comb begin
    dist_o = 2'd0;
    if (ex_hit) begin
      dist_o = 2'd3;
    end else if (mem_hit) begin
      dist_o = 2'd2;
    end else if (wb_hit) begin
      dist_o = 2'd1;
    end
  end

  assign match_o = (dist_o != 2'd0);

endmodule

// File: rtl/hazard_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline: counted RAW stalls,
// EX jump / MEM branch redirects, and saturating stall/redirect counters.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [RA_W-1:0]  id_rs_i,
  input  logic [RA_W-1:0]  id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [RA_W-1:0]  ex_wreg_i,
  input  logic [RA_W-1:0]  mem_wreg_i,
  input  logic [RA_W-1:0]  wb_wreg_i,
  input  logic             ex_regwrite_i,
  input  logic             mem_regwrite_i,
  input  logic             wb_regwrite_i,
  input  logic             ex_jump_i,
  input  logic             mem_br_taken_i,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc;
  logic             flush_inc;
  logic             hz_match;
  logic [1:0]       hz_dist;
  ctrl_t            ctrl;

  hazard_match u_match (
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_use_rs_i    (id_use_rs_i),
    .id_use_rt_i    (id_use_rt_i),
    .ex_wreg_i      (ex_wreg_i),
    .mem_wreg_i     (mem_wreg_i),
    .wb_wreg_i      (wb_wreg_i),
    .ex_regwrite_i  (ex_regwrite_i),
    .mem_regwrite_i (mem_regwrite_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .match_o        (hz_match),
    .dist_o         (hz_dist)
  );

  // Redirects abort a pending stall; inputs are not re-checked while STALL runs.
  always_comb begin
    state_d   = ST_RUN;
    rem_d     = 2'd0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    ctrl      = CTRL_SEQ;
    if (state_q == ST_INIT) begin
      ctrl = CTRL_HOLD;
    end else if (mem_br_taken_i) begin
      ctrl      = CTRL_BR;
      flush_inc = 1'b1;
    end else if (ex_jump_i) begin
      ctrl      = CTRL_JMP;
      flush_inc = 1'b1;
    end else if (state_q == ST_STALL) begin
      ctrl      = CTRL_STALL;
      stall_inc = 1'b1;
      if (rem_q > 2'd1) begin
        state_d = ST_STALL;
        rem_d   = rem_q - 2'd1;
      end
    end else if (hz_match) begin
      ctrl      = CTRL_STALL;
      stall_inc = 1'b1;
      if (hz_dist > 2'd1) begin
        state_d = ST_STALL;
        rem_d   = hz_dist - 2'd1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_inc && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_INIT;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_we_o       = ctrl.pc_we;
  assign pc_sel_o      = ctrl.pc_sel;
  assign ifid_we_o     = ctrl.ifid_we;
  assign ifid_flush_o  = ctrl.ifid_flush;
  assign idex_bubble_o = ctrl.idex_bubble;
  assign exmem_flush_o = ctrl.exmem_flush;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

  // A flushed IF/ID must never also be loaded with the fetched word.
  a_flush_excl : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                  !(ifid_we_o && ifid_flush_o));

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: a cycle-level reference model pushes expected
// outputs, a monitor pops and compares on each falling edge.
module tb_hazard_sched;
  import hazard_sched_pkg::*;

  typedef struct {
    logic       rstN;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] exW;
    logic [4:0] memW;
    logic [4:0] wbW;
    logic       exR;
    logic       memR;
    logic       wbR;
    logic       jmp;
    logic       br;
  } stim_t;

  typedef struct {
    logic        pcWe;
    logic [1:0]  pcSel;
    logic        ifidWe;
    logic        ifidFlush;
    logic        idexBubble;
    logic        exmemFlush;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
    logic [1:0]  stallCntS;
    logic [1:0]  flushCntS;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [4:0]  idRs, idRt, exWreg, memWreg, wbWreg;
  logic        idUseRs, idUseRt, exRegwrite, memRegwrite, wbRegwrite, exJump, memBrTaken;
  logic        pcWe, ifidWe, ifidFlush, idexBubble, exmemFlush;
  logic [1:0]  pcSel;
  logic [15:0] stallCnt, flushCnt;
  logic        pcWeS, ifidWeS, ifidFlushS, idexBubbleS, exmemFlushS;
  logic [1:0]  pcSelS;
  logic [1:0]  stallCntS, flushCntS;

  int   totalChecks = 0;
  int   badChecks = 0;
  exp_t expQ[$];

  bit   mInit = 1'b1;
  int   stallLeft = 0;
  int   stallCount = 0;
  int   flushCount = 0;

  always #5 clk = ~clk;

  hazard_sched #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rstN),
    .id_rs_i(idRs), .id_rt_i(idRt), .id_use_rs_i(idUseRs), .id_use_rt_i(idUseRt),
    .ex_wreg_i(exWreg), .mem_wreg_i(memWreg), .wb_wreg_i(wbWreg),
    .ex_regwrite_i(exRegwrite), .mem_regwrite_i(memRegwrite), .wb_regwrite_i(wbRegwrite),
    .ex_jump_i(exJump), .mem_br_taken_i(memBrTaken),
    .pc_we_o(pcWe), .pc_sel_o(pcSel), .ifid_we_o(ifidWe), .ifid_flush_o(ifidFlush),
    .idex_bubble_o(idexBubble), .exmem_flush_o(exmemFlush),
    .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );

  // Narrow-counter copy driven identically, so saturation is reached quickly.
  hazard_sched #(.CNT_W(2)) dutSmall (
    .clk_i(clk), .rst_n_i(rstN),
    .id_rs_i(idRs), .id_rt_i(idRt), .id_use_rs_i(idUseRs), .id_use_rt_i(idUseRt),
    .ex_wreg_i(exWreg), .mem_wreg_i(memWreg), .wb_wreg_i(wbWreg),
    .ex_regwrite_i(exRegwrite), .mem_regwrite_i(memRegwrite), .wb_regwrite_i(wbRegwrite),
    .ex_jump_i(exJump), .mem_br_taken_i(memBrTaken),
    .pc_we_o(pcWeS), .pc_sel_o(pcSelS), .ifid_we_o(ifidWeS), .ifid_flush_o(ifidFlushS),
    .idex_bubble_o(idexBubbleS), .exmem_flush_o(exmemFlushS),
    .stall_cnt_o(stallCntS), .flush_cnt_o(flushCntS)
  );

  function automatic int satTo(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Stall length owed to the ID instruction: 3 behind EX, 2 behind MEM, 1 behind WB.
  function automatic int rawDistance(input stim_t s);
    logic [4:0] w[3];
    logic       r[3];
    int         best;
    best = 0;
    w = '{s.exW, s.memW, s.wbW};
    r = '{s.exR, s.memR, s.wbR};
    for (int i = 0; i < 3; i++) begin
      if (r[i] && (w[i] != 5'd0) &&
          ((s.urs && (s.rs == w[i])) || (s.urt && (s.rt == w[i])))) begin
        if ((3 - i) > best) best = 3 - i;
      end
    end
    return best;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s = '{rstN: 1'b1, rs: 5'd0, rt: 5'd0, urs: 1'b0, urt: 1'b0, exW: 5'd0, memW: 5'd0,
          wbW: 5'd0, exR: 1'b0, memR: 1'b0, wbR: 1'b0, jmp: 1'b0, br: 1'b0};
    return s;
  endfunction

  function automatic void setCtrl(inout exp_t e, input logic pw, input logic [1:0] ps,
                                  input logic iw, input logic ifl, input logic bub,
                                  input logic efl);
    e.pcWe = pw; e.pcSel = ps; e.ifidWe = iw;
    e.ifidFlush = ifl; e.idexBubble = bub; e.exmemFlush = efl;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    int   d;
    @(posedge clk);
    #1;
    rstN = s.rstN; idRs = s.rs; idRt = s.rt; idUseRs = s.urs; idUseRt = s.urt;
    exWreg = s.exW; memWreg = s.memW; wbWreg = s.wbW;
    exRegwrite = s.exR; memRegwrite = s.memR; wbRegwrite = s.wbR;
    exJump = s.jmp; memBrTaken = s.br;
    if (!s.rstN) begin
      mInit = 1'b1; stallLeft = 0; stallCount = 0; flushCount = 0;
    end
    e.stallCnt  = 16'(satTo(stallCount, 65535));
    e.flushCnt  = 16'(satTo(flushCount, 65535));
    e.stallCntS = 2'(satTo(stallCount, 3));
    e.flushCntS = 2'(satTo(flushCount, 3));
    setCtrl(e, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    if (!s.rstN || mInit) begin
      setCtrl(e, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
      if (s.rstN) mInit = 1'b0;
    end else if (s.br) begin
      setCtrl(e, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
      flushCount++; stallLeft = 0;
    end else if (s.jmp) begin
      setCtrl(e, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
      flushCount++; stallLeft = 0;
    end else if (stallLeft > 0) begin
      setCtrl(e, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      stallCount++; stallLeft--;
    end else begin
      d = rawDistance(s);
      if (d > 0) begin
        setCtrl(e, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        stallCount++; stallLeft = d - 1;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] req);
    totalChecks++;
    if (act !== req) begin
      badChecks++;
      $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("pc_we",       16'(pcWe),        16'(e.pcWe));
    checkField("pc_sel",      16'(pcSel),       16'(e.pcSel));
    checkField("ifid_we",     16'(ifidWe),      16'(e.ifidWe));
    checkField("ifid_flush",  16'(ifidFlush),   16'(e.ifidFlush));
    checkField("idex_bubble", 16'(idexBubble),  16'(e.idexBubble));
    checkField("exmem_flush", 16'(exmemFlush),  16'(e.exmemFlush));
    checkField("stall_cnt",   stallCnt,         e.stallCnt);
    checkField("flush_cnt",   flushCnt,         e.flushCnt);
    checkField("small_ctrl",
               16'({pcWeS, pcSelS, ifidWeS, ifidFlushS, idexBubbleS, exmemFlushS}),
               16'({e.pcWe, e.pcSel, e.ifidWe, e.ifidFlush, e.idexBubble, e.exmemFlush}));
    checkField("small_stall_cnt", 16'(stallCntS), 16'(e.stallCntS));
    checkField("small_flush_cnt", 16'(flushCntS), 16'(e.flushCntS));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    rstN = 1'b1;
    idRs = '0; idRt = '0; idUseRs = 1'b0; idUseRt = 1'b0;
    exWreg = '0; memWreg = '0; wbWreg = '0;
    exRegwrite = 1'b0; memRegwrite = 1'b0; wbRegwrite = 1'b0;
    exJump = 1'b0; memBrTaken = 1'b0;
    #2 rstN = 1'b0;

    s = idleStim(); s.rstN = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    for (int i = 0; i < 2; i++) applyStimulus(idleStim());

    // EX writer of $3 read through rs: three-cycle stall
    s = idleStim(); s.exW = 5'd3; s.exR = 1'b1; s.rs = 5'd3; s.urs = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 4; i++) applyStimulus(idleStim());

    // WB writer of $3 read through rt: single stall cycle
    s = idleStim(); s.wbW = 5'd3; s.wbR = 1'b1; s.rt = 5'd3; s.urt = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());

    // $0 writer in EX never stalls
    s = idleStim(); s.exW = 5'd0; s.exR = 1'b1; s.rs = 5'd0; s.urs = 1'b1;
    applyStimulus(s);

    s = idleStim(); s.jmp = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());

    // Branch plus jump arriving on the second stall cycle
    s = idleStim(); s.exW = 5'd3; s.exR = 1'b1; s.rs = 5'd3; s.urs = 1'b1;
    applyStimulus(s);
    s = idleStim(); s.br = 1'b1; s.jmp = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 2; i++) applyStimulus(idleStim());

    // Reset in the middle of a stall
    s = idleStim(); s.memW = 5'd7; s.memR = 1'b1; s.rt = 5'd7; s.urt = 1'b1;
    applyStimulus(s);
    s = idleStim(); s.exW = 5'd5; s.exR = 1'b1; s.rs = 5'd5; s.urs = 1'b1;
    applyStimulus(s);
    s = idleStim(); s.rstN = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(s);
    for (int i = 0; i < 3; i++) applyStimulus(idleStim());

    for (int n = 0; n < 800; n++) begin
      s.rstN = ($urandom_range(0, 149) != 0);
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.urs  = 1'($urandom_range(0, 1));
      s.urt  = 1'($urandom_range(0, 1));
      s.exW  = 5'($urandom_range(0, 3));
      s.memW = 5'($urandom_range(0, 3));
      s.wbW  = 5'($urandom_range(0, 3));
      s.exR  = 1'($urandom_range(0, 1));
      s.memR = 1'($urandom_range(0, 1));
      s.wbR  = 1'($urandom_range(0, 1));
      s.jmp  = ($urandom_range(0, 9) == 0);
      s.br   = ($urandom_range(0, 11) == 0);
      applyStimulus(s);
    end

    for (int i = 0; i < 8 && expQ.size() != 0; i++) @(negedge clk);
    #1;
    totalChecks++;
    if (expQ.size() != 0) begin
      badChecks++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
